// File: rtl/debounce_toggle.sv
// Push-button debouncer with a two-flop synchronizer and a press/release FSM.
// It emits a one-cycle T pulse per accepted press and a registered debounced level.
module debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic T,
  output logic level
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic        s1_reg;
  logic        btn_s;
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        t_reg, t_next;
  logic        level_reg, level_next;

  // btn is asynchronous; only btn_s is used beyond this point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_reg <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      s1_reg <= btn;
      btn_s  <= s1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      t_reg     <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      t_reg     <= t_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // a bounce back high returns to HELD without a new pulse
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // outputs are registered from the next-state so they change on the accepting edge
    t_next     = (state_reg == PRESS_WAIT) && (state_next == HELD);
    level_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
  end

  assign T     = t_reg;
  assign level = level_reg;

endmodule

// File: tb/tb_debounce_toggle.sv
// Directed bench for debounce_toggle (DEBOUNCE_CYCLES=4) with a downstream T flip-flop.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_debounce_toggle;

  logic clk;
  logic rst;
  logic btn;
  logic T;
  logic level;
  logic q;
  int   n_checks;
  int   n_fail;

  debounce_toggle #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .T    (T),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream T flip-flop driven by the pulse
  always @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else if (T) q <= ~q;
  end

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    btn      = 1'b0;

    // reset state
    #1;
    chk("reset_T", T, 1'b0);
    chk("reset_level", level, 1'b0);
    repeat (2) tick();
    chk("reset_T_clk", T, 1'b0);
    chk("reset_level_clk", level, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_T", T, 1'b0);
    chk("idle_level", level, 1'b0);

    // a) clean press held 20 cycles: pulse on edge 7 only, level from edge 7
    btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("a_T_e%0d", i), T, (i == 7));
      chk($sformatf("a_level_e%0d", i), level, (i >= 7));
      $display("a: edge %0d T=%b level=%b", i, T, level);
    end
    btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("a_rel_T_e%0d", i), T, 1'b0);
      chk($sformatf("a_rel_level_e%0d", i), level, (i < 7));
    end

    // b) bounce 1,0,1,0 then steady 1
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0);
      tick();
      chk($sformatf("b_bounce_T_%0d", i), T, 1'b0);
      chk($sformatf("b_bounce_level_%0d", i), level, 1'b0);
    end
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("b_T_e%0d", i), T, (i == 7));
      chk($sformatf("b_level_e%0d", i), level, (i >= 7));
      $display("b: edge %0d T=%b level=%b", i, T, level);
    end

    // c) release bounce from HELD: 0,0,1 then steady 0
    btn = 1'b0; tick();
    chk("c_pre0_level", level, 1'b1);
    tick();
    chk("c_pre1_level", level, 1'b1);
    btn = 1'b1; tick();
    chk("c_pre2_level", level, 1'b1);
    btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("c_T_e%0d", i), T, 1'b0);
      chk($sformatf("c_level_e%0d", i), level, (i < 7));
      $display("c: edge %0d T=%b level=%b", i, T, level);
    end

    // d) 3-cycle glitch from IDLE
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) btn = 1'b0;
      tick();
      chk($sformatf("d_T_e%0d", i), T, 1'b0);
      chk($sformatf("d_level_e%0d", i), level, 1'b0);
    end

    // e) reset during the T=1 cycle, then re-press with btn still high
    btn = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    chk("e_T_before_reset", T, 1'b1);
    chk("e_level_before_reset", level, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("e_T_async_reset", T, 1'b0);
    chk("e_level_async_reset", level, 1'b0);
    $display("e: reset asserted T=%b level=%b", T, level);
    repeat (2) tick();
    chk("e_T_in_reset", T, 1'b0);
    chk("e_level_in_reset", level, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("e_T_e%0d", i), T, (i == 7));
      chk($sformatf("e_level_e%0d", i), level, (i >= 7));
      $display("e: edge %0d T=%b level=%b", i, T, level);
    end

    // f) three clean presses toggle the downstream flip-flop 0->1->0->1
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("f_q_start", q, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        chk($sformatf("f%0d_T_e%0d", k, i), T, (i == 7));
        if (i == 7) chk($sformatf("f%0d_q_before", k), q, (k % 2 == 0));
      end
      chk($sformatf("f%0d_q_after", k), q, (k % 2 == 1));
      btn = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      chk($sformatf("f%0d_level_released", k), level, 1'b0);
      chk($sformatf("f%0d_q_hold", k), q, (k % 2 == 1));
      $display("f: press %0d q=%b", k, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_toggle.md
DEBOUNCE_TOGGLE -- requirements
Module: debounce_toggle

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive synchronized samples needed to accept a level change. Legal values are 2 to 2^16.
REQ-002 The block SHALL have the following ports, listed clock and reset first:
  clk    input   1   single clock; all state changes on its rising edge
  rst    input   1   asynchronous, active-low reset (0 = reset)
  btn    input   1   raw, asynchronous, bouncing push-button level (1 = pressed)
  T      output  1   one-cycle toggle pulse per accepted press; drives the T input of the downstream T flip-flop
  level  output  1   debounced button level
REQ-003 All outputs SHALL be registered; there SHALL be no combinational path from btn to any output.

Function
REQ-004 btn SHALL pass through a 2-flop synchronizer. Its output btn_s is the only internal view of btn.
REQ-005 The block SHALL contain a counter cnt, 16 bits wide, and a 4-state machine with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-006 IDLE behaviour:
  btn_s=1 -> PRESS_WAIT, cnt=0
  otherwise stay in IDLE
REQ-007 PRESS_WAIT behaviour:
  btn_s=0 -> IDLE, cnt=0
  btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1
  btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD, cnt=0
REQ-008 HELD behaviour:
  btn_s=0 -> RELEASE_WAIT, cnt=0
  otherwise stay in HELD
REQ-009 RELEASE_WAIT behaviour:
  btn_s=1 -> HELD, cnt=0 (release bounce, no new pulse)
  btn_s=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1
  btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, cnt=0
REQ-010 T SHALL be 1 for exactly the one cycle following the PRESS_WAIT->HELD transition, and 0 in every other cycle.
REQ-011 level SHALL be 1 exactly when the state is HELD or RELEASE_WAIT.
REQ-012 Latency: with btn held high continuously, T SHALL rise after the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge sampling btn=1; level SHALL rise on the same edge.
REQ-013 Release latency: with btn held low continuously from HELD, level SHALL fall after the (DEBOUNCE_CYCLES+3)th edge sampling btn=0.
REQ-014 Pulse rate: a new T pulse SHALL require a full return to IDLE. Holding btn high indefinitely SHALL produce exactly one pulse.
REQ-015 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-016 Any btn glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no T pulse and no change on level.

Reset
REQ-017 While rst=0, asynchronously: state=IDLE, cnt=0, both synchronizer flops=0, T=0, level=0.
REQ-018 Reset asserted mid-operation, in any state (including the cycle T=1), SHALL force T=0 immediately and discard the press in progress.
REQ-019 After rst rises, a btn already held high SHALL be treated as a new press: one T pulse per REQ-012.

Verification (DEBOUNCE_CYCLES=4)
REQ-020 The bench SHALL cover these directed scenarios:
  a) clean press: btn 0->1 and held 20 cycles -> exactly one T pulse 1 cycle wide, after 7 edges; level=1 from the same edge.
  b) bounce: btn toggles 1,0,1,0 over 4 cycles, then stays 1 -> no pulse during the bounce; exactly one T pulse 7 edges after the final rise.
  c) release bounce: from HELD, btn 0 for 2 cycles, 1 for 1 cycle, then 0 -> no T pulse; level falls 7 edges after the final fall.
  d) glitch: from IDLE, btn=1 for 3 cycles -> T=0 and level=0 throughout.
  e) reset: rst=0 asserted between clock edges in the cycle T=1 -> T and level go 0 immediately; rst released with btn=1 -> one new pulse 7 edges later.
  f) chained with the downstream T flip-flop: 3 clean presses -> the flip-flop output Q toggles exactly 3 times (0->1->0->1).
